// File: rtl/mem_image_loader_if.sv
// Byte-stream, cell-memory write port and core handshake bundle for mem_image_loader.
// The loader sits on the slave modport; the upstream/harness side uses master.
interface mem_image_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  core_idle;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [15:0]           core_expr;
    logic                  core_start;
    logic                  busy;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        output in_valid, in_data, core_idle,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_expr, core_start,
               busy, err, err_code
    );

    modport slave (
        input  in_valid, in_data, core_idle,
        output in_ready, mem_we, mem_addr, mem_wdata, core_expr, core_start,
               busy, err, err_code
    );
endinterface

// File: rtl/mem_image_loader.sv
// Parses a framed byte stream into cell-memory word writes and, on a good
// checksum, hands the root expression pointer to the core with a start pulse.
module mem_image_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_image_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO,
        ROOT_HI, ROOT_LO, CHECK, START
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            hi_q;
    logic [7:0]            csum_q;
    logic [15:0]           addr_q;
    logic [15:0]           cnt_q;
    logic [15:0]           root_q;
    logic                  in_ready_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [15:0]           core_expr_q;
    logic                  core_start_q;
    logic                  busy_q;
    logic                  err_q;
    logic [1:0]            err_code_q;

    logic accept;
    logic range_bad;
    logic is_header;

    assign accept    = bus.in_valid && in_ready_q;
    assign is_header = (bus.in_data == HEADER);
    // 17-bit sum so a frame ending exactly at the top of memory is legal
    assign range_bad = (17'(addr_q) + 17'({hi_q, bus.in_data})) > 17'(DEPTH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_header && bus.core_idle) state_d = ADDR_HI;
            ADDR_HI: if (accept) state_d = ADDR_LO;
            ADDR_LO: if (accept) state_d = CNT_HI;
            CNT_HI:  if (accept) state_d = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (range_bad)                        state_d = IDLE;
                    else if ({hi_q, bus.in_data} == 16'd0) state_d = ROOT_HI;
                    else                                  state_d = DATA_HI;
                end
            end
            DATA_HI: if (accept) state_d = DATA_LO;
            DATA_LO: if (accept) state_d = (cnt_q == 16'd1) ? ROOT_HI : DATA_HI;
            ROOT_HI: if (accept) state_d = ROOT_LO;
            ROOT_LO: if (accept) state_d = CHECK;
            CHECK:   if (accept) state_d = (bus.in_data == csum_q) ? START : IDLE;
            START:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            csum_q       <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            root_q       <= '0;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_expr_q  <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d != START);
            busy_q       <= (state_d != IDLE);
            mem_we_q     <= 1'b0;
            core_start_q <= 1'b0;

            if (accept) begin
                if (state_q != IDLE && state_q != CHECK) csum_q <= csum_q ^ bus.in_data;
                case (state_q)
                    IDLE: begin
                        if (is_header) begin
                            if (bus.core_idle) begin
                                err_q      <= 1'b0;
                                err_code_q <= 2'd0;
                                csum_q     <= '0;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= 2'd3;
                            end
                        end
                    end
                    ADDR_HI, CNT_HI, DATA_HI, ROOT_HI: hi_q <= bus.in_data;
                    ADDR_LO: addr_q <= {hi_q, bus.in_data};
                    CNT_LO: begin
                        cnt_q <= {hi_q, bus.in_data};
                        if (range_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                        end
                    end
                    DATA_LO: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q[ADDR_WIDTH-1:0];
                        mem_wdata_q <= DATA_WIDTH'({hi_q, bus.in_data});
                        addr_q      <= addr_q + 16'd1;
                        cnt_q       <= cnt_q - 16'd1;
                    end
                    ROOT_LO: root_q <= {hi_q, bus.in_data};
                    CHECK: begin
                        if (bus.in_data != csum_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // root pointer only becomes visible to the core with its start pulse
            if (state_q == START) begin
                core_expr_q  <= root_q;
                core_start_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_expr  = core_expr_q;
    assign bus.core_start = core_start_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
endmodule
